regfile_mp: RTL and testbench

- Parametrised multi-port integer register file; successor to the single-write, 2-read, 32x32 file in the CPU datapath.
- Adds configurable width, depth, read- and write-port count, and an optional hardwired-zero register 0.
- Adds write-to-read bypass and a sequential post-reset initialisation sweep with a `ready` flag.
- Sits between decode (read addresses) and writeback (write ports); also drives a selectable debug probe.

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_mp_read_port.sv | 54 +++++
 rtl/regfile_mp.sv | 124 ++++++++++++
 tb/tb_regfile_mp.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and constants for the multi-port register file.
package regfile_pkg;

    // The FSM has two states: the post-reset initialisation sweep, then normal operation.
    typedef enum logic {
        INIT,
        RUN
    } rf_state_t;

    // Values for INIT_MODE: what the sweep writes into each entry.
    localparam int INIT_ZERO  = 0;
    localparam int INIT_INDEX = 1;

endpackage

// File: rtl/regfile_mp_read_port.sv
// One read lane: applies the zero-register rule, the address range check,
// and the write-to-read bypass with highest-port-wins priority.
module rf_read_port
    import regfile_pkg::*;
#(
    parameter int W        = 32,
    parameter int DEPTH    = 32,
    parameter int AW       = $clog2(DEPTH),
    parameter int NW       = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              active,
    input  logic [AW-1:0]     ra,
    input  logic [W-1:0]      row,
    input  logic [NW-1:0]     we,
    input  logic [NW*AW-1:0]  wa,
    input  logic [NW*W-1:0]   wd,
    output logic [W-1:0]      rd
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic          in_range;
    logic          is_zero;
    logic          byp_hit;
    logic [W-1:0]  byp_data;

    assign in_range = ({1'b0, ra} < DEPTH_W);
    assign is_zero  = (ZERO_REG != 0) && (ra == '0);

    // Find the highest-numbered enabled write port aimed at this read address.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
        byp_hit  = 1'b0;
        byp_data = '0;
        // NOTE: ports are scanned in ascending order, so the last match (highest port) wins.
        for (int p = 0; p < NW; p++) begin
            if (we[p] && (wa[p*AW +: AW] == ra)) begin
                byp_hit  = 1'b1;
                byp_data = wd[p*W +: W];
            end
        end
    end

    // Invalid, zero-register and not-yet-initialised reads return 0; otherwise row or bypass.
    always_comb begin
        rd = '0;
        if (active && in_range && !is_zero) begin
            rd = ((BYPASS != 0) && byp_hit) ? byp_data : row;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with post-reset initialisation sweep,
// optional hardwired-zero register 0, optional write-to-read bypass, and a debug probe.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int W         = 32,
    parameter int DEPTH     = 32,
    parameter int AW        = $clog2(DEPTH),
    parameter int NR        = 2,
    parameter int NW        = 2,
    parameter int ZERO_REG  = 1,
    parameter int BYPASS    = 1,
    parameter int INIT_MODE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NW-1:0]     we,
    input  logic [NW*AW-1:0]  wa,
    input  logic [NW*W-1:0]   wd,
    input  logic [NR*AW-1:0]  ra,
    output logic [NR*W-1:0]   rd,
    input  logic [AW-1:0]     probe_sel,
    output logic [W-1:0]      probe,
    output logic              ready
);

    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);
    localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);

    rf_state_t      state, state_d;
    logic [AW-1:0]  ptr, ptr_d;
    logic [W-1:0]   mem [DEPTH];
    logic [W-1:0]   init_val;
    logic [NW-1:0]  wr_ok;
    logic           active;
    logic           probe_ok;

    assign active   = (state == RUN);
    assign ready    = active;
    assign init_val = (INIT_MODE == INIT_INDEX) ? W'(ptr) : '0;

    // State register and sweep pointer; both restart on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= INIT;
            ptr   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state <= state_d;
            ptr   <= ptr_d;
        end
    end

    // Sweep advances one entry per cycle and hands over to RUN after the last entry.
    always_comb begin
        state_d = state;
        ptr_d   = ptr;
        if (state == INIT) begin
            if (ptr == LAST) begin
                state_d = RUN;
                ptr_d   = '0;
            end else begin
                ptr_d = ptr + 1'b1;
            end
        end
    end

    // Per-port write qualification: in range, not the hardwired zero register.
    always_comb begin
        wr_ok = '0;
        for (int p = 0; p < NW; p++) begin
            wr_ok[p] = we[p]
                     && ({1'b0, wa[p*AW +: AW]} < DEPTH_W)
                     && !((ZERO_REG != 0) && (wa[p*AW +: AW] == '0));
        end
    end

    // Storage: sweep fill during INIT, otherwise commit qualified writes (highest port last).
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset; the sweep gives it defined contents instead.
        if (state == INIT) begin
            mem[ptr] <= init_val;
        end else begin
            for (int p = 0; p < NW; p++) begin
                if (wr_ok[p]) begin
                    mem[wa[p*AW +: AW]] <= wd[p*W +: W];
                end
            end
        end
    end

    // One read lane per port; the row is guarded so out-of-range addresses never index the array.
    for (genvar i = 0; i < NR; i++) begin : g_rd
        logic [AW-1:0] ra_i;
        logic [W-1:0]  row;

        assign ra_i = ra[i*AW +: AW];
        assign row  = ({1'b0, ra_i} < DEPTH_W) ? mem[ra_i] : '0;

        rf_read_port #(
            .W        (W),
            .DEPTH    (DEPTH),
            .AW       (AW),
            .NW       (NW),
            .ZERO_REG (ZERO_REG),
            .BYPASS   (BYPASS)
        ) u_port (
            .active (active),
            .ra     (ra_i),
            .row    (row),
            .we     (we),
            .wa     (wa),
            .wd     (wd),
            .rd     (rd[i*W +: W])
        );
    end

    // Debug probe reads the array directly and is never bypassed.
    assign probe_ok = active
                   && ({1'b0, probe_sel} < DEPTH_W)
                   && !((ZERO_REG != 0) && (probe_sel == '0));
    assign probe    = probe_ok ? mem[probe_sel] : '0;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two instances side by side (default config, and a
// DEPTH=24 / no-bypass / no-zero-reg / zero-fill config) share all stimulus.
module tb_regfile_mp;
    import regfile_pkg::*;

    logic        clk;
    logic        rst;
    logic [1:0]  we;
    logic [9:0]  wa;
    logic [63:0] wd;
    logic [9:0]  ra;
    logic [4:0]  probe_sel;
    logic [63:0] rd_m, rd_a;
    logic [31:0] probe_m, probe_a;
    logic        ready_m, ready_a;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state: contents and sweep progress per configuration.
    logic [31:0] mm [2][32];
    int          sweep [2];

    regfile_mp #(
        .INIT_MODE (INIT_INDEX)
    ) u_main (
        .clk       (clk),
        .rst       (rst),
        .we        (we),
        .wa        (wa),
        .wd        (wd),
        .ra        (ra),
        .rd        (rd_m),
        .probe_sel (probe_sel),
        .probe     (probe_m),
        .ready     (ready_m)
    );

    regfile_mp #(
        .DEPTH     (24),
        .AW        (5),
        .ZERO_REG  (0),
        .BYPASS    (0),
        .INIT_MODE (INIT_ZERO)
    ) u_alt (
        .clk       (clk),
        .rst       (rst),
        .we        (we),
        .wa        (wa),
        .wd        (wd),
        .ra        (ra),
        .rd        (rd_a),
        .probe_sel (probe_sel),
        .probe     (probe_a),
        .ready     (ready_a)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Configuration 0 = u_main, 1 = u_alt.
    function automatic int  cfg_depth (int c); return (c == 0) ? 32 : 24; endfunction
    function automatic bit  cfg_zero  (int c); return (c == 0);          endfunction
    function automatic bit  cfg_byp   (int c); return (c == 0);          endfunction
    function automatic bit  cfg_index (int c); return (c == 0);          endfunction

    function automatic bit m_ready(int c);
        return sweep[c] >= cfg_depth(c);
    endfunction

    // Value a read port should show right now, from the architectural rules.
    function automatic logic [31:0] m_read(int c, int a, bit is_rd);
        logic [31:0] r;
        if (!m_ready(c) || a >= cfg_depth(c)) return 32'h0;
        if (cfg_zero(c) && a == 0) return 32'h0;
        r = mm[c][a];
        if (is_rd && cfg_byp(c)) begin
            for (int p = 1; p >= 0; p--) begin
                if (we[p] && int'(wa[p*5 +: 5]) == a) begin
                    r = wd[p*32 +: 32];
                    break;
                end
            end
        end
        return r;
    endfunction

    // Apply one rising edge to the model.
    function automatic void model_commit();
        for (int c = 0; c < 2; c++) begin
            if (!rst) continue;
            if (!m_ready(c)) begin
                mm[c][sweep[c]] = cfg_index(c) ? 32'(sweep[c]) : 32'h0;
                sweep[c]++;
            end else begin
                for (int a = 0; a < cfg_depth(c); a++) begin
                    for (int p = 1; p >= 0; p--) begin
                        if (we[p] && int'(wa[p*5 +: 5]) == a) begin
                            if (!(cfg_zero(c) && a == 0)) mm[c][a] = wd[p*32 +: 32];
                            break;
                        end
                    end
                end
            end
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic tick();
        model_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        sweep[0] = 0;
        sweep[1] = 0;
        #2;
        check("ready_m in reset", 32'(ready_m), 32'h0);
        check("ready_a in reset", 32'(ready_a), 32'h0);
        rst = 1'b1;
        #1;
    endtask

    task automatic compare_model(input string tag);
        logic [63:0] r;
        logic [31:0] pb;
        logic        rdy;
        for (int c = 0; c < 2; c++) begin
            r   = (c == 0) ? rd_m : rd_a;
            pb  = (c == 0) ? probe_m : probe_a;
            rdy = (c == 0) ? ready_m : ready_a;
            check($sformatf("%s c%0d ready", tag, c), 32'(rdy), 32'(m_ready(c)));
            for (int i = 0; i < 2; i++)
                check($sformatf("%s c%0d rd%0d ra=%0d", tag, c, i, ra[i*5 +: 5]),
                      r[i*32 +: 32], m_read(c, int'(ra[i*5 +: 5]), 1'b1));
            check($sformatf("%s c%0d probe sel=%0d", tag, c, probe_sel),
                  pb, m_read(c, int'(probe_sel), 1'b0));
        end
    endtask

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0, wa1;
        logic [31:0] wd0, wd1;
        logic [4:0]  ra0, ra1, ps;
        logic [31:0] m0, m1, mp;
        logic [31:0] a0, a1, ap;
    } vec_t;

    vec_t vecs [13];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; we = '0; wa = '0; wd = '0; ra = '0; probe_sel = '0;
        sweep[0] = 0; sweep[1] = 0;

        // Directed vectors, applied right after a fresh sweep (main: reg i = i, alt: all zero).
        vecs[0]  = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,    5'd5,  5'd31, 5'd31,
                     32'd5,        32'd31,       32'd31,       32'h0,  32'h0, 32'h0};
        vecs[1]  = '{2'b01, 5'd3,  5'd0,  32'hDEADBEEF, 32'h0,    5'd3,  5'd3,  5'd3,
                     32'hDEADBEEF, 32'hDEADBEEF, 32'd3,        32'h0,  32'h0, 32'h0};
        vecs[2]  = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,    5'd3,  5'd3,  5'd3,
                     32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[3]  = '{2'b11, 5'd7,  5'd7,  32'h11,       32'h22,   5'd7,  5'd7,  5'd7,
                     32'h22,       32'h22,       32'd7,        32'h0,  32'h0, 32'h0};
        vecs[4]  = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,    5'd7,  5'd7,  5'd7,
                     32'h22,       32'h22,       32'h22,       32'h22, 32'h22, 32'h22};
        vecs[5]  = '{2'b11, 5'd8,  5'd9,  32'h88,       32'h99,   5'd8,  5'd9,  5'd9,
                     32'h88,       32'h99,       32'd9,        32'h0,  32'h0, 32'h0};
        vecs[6]  = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,    5'd8,  5'd9,  5'd8,
                     32'h88,       32'h99,       32'h88,       32'h88, 32'h99, 32'h88};
        vecs[7]  = '{2'b01, 5'd0,  5'd0,  32'hFFFF,     32'h0,    5'd0,  5'd1,  5'd0,
                     32'h0,        32'd1,        32'h0,        32'h0,  32'h0, 32'h0};
        vecs[8]  = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,    5'd0,  5'd1,  5'd0,
                     32'h0,        32'd1,        32'h0,        32'hFFFF, 32'h0, 32'hFFFF};
        vecs[9]  = '{2'b01, 5'd30, 5'd0,  32'h55,       32'h0,    5'd30, 5'd30, 5'd30,
                     32'h55,       32'h55,       32'd30,       32'h0,  32'h0, 32'h0};
        vecs[10] = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,    5'd30, 5'd23, 5'd30,
                     32'h55,       32'd23,       32'h55,       32'h0,  32'h0, 32'h0};
        vecs[11] = '{2'b10, 5'd0,  5'd12, 32'h0,        32'hABCD, 5'd12, 5'd13, 5'd12,
                     32'hABCD,     32'd13,       32'd12,       32'h0,  32'h0, 32'h0};
        vecs[12] = '{2'b00, 5'd0,  5'd0,  32'h0,        32'h0,    5'd12, 5'd13, 5'd13,
                     32'hABCD,     32'd13,       32'd13,       32'hABCD, 32'h0, 32'h0};

        @(posedge clk);
        #1;

        // Sweep timing and values: ready after DEPTH cycles, outputs 0 until then.
        ra = {5'd1, 5'd5};
        probe_sel = 5'd31;
        do_reset();
        for (int k = 0; k <= 34; k++) begin
            #1;
            check($sformatf("sweep k=%0d ready_m", k), 32'(ready_m), 32'(k >= 32));
            check($sformatf("sweep k=%0d ready_a", k), 32'(ready_a), 32'(k >= 24));
            check($sformatf("sweep k=%0d rd0_m", k), rd_m[31:0], (k >= 32) ? 32'd5 : 32'd0);
            check($sformatf("sweep k=%0d rd1_m", k), rd_m[63:32], (k >= 32) ? 32'd1 : 32'd0);
            check($sformatf("sweep k=%0d probe_m", k), probe_m, (k >= 32) ? 32'd31 : 32'd0);
            check($sformatf("sweep k=%0d rd0_a", k), rd_a[31:0], 32'd0);
            check($sformatf("sweep k=%0d probe_a", k), probe_a, 32'd0);
            tick();
        end

        // Reset mid-sweep with writes attempted during INIT.
        we = 2'b01; wa = {5'd0, 5'd4}; wd = {32'h0, 32'h99}; ra = {5'd4, 5'd4};
        do_reset();
        for (int k = 0; k < 10; k++) begin
            #1;
            check($sformatf("init write k=%0d rd0_m", k), rd_m[31:0], 32'd0);
            tick();
        end
        rst = 1'b0;
        sweep[0] = 0;
        sweep[1] = 0;
        #1;
        check("mid-sweep reset ready_m", 32'(ready_m), 32'h0);
        rst = 1'b1;
        #1;
        for (int k = 0; k <= 34; k++) begin
            we = (k < 20) ? 2'b01 : 2'b00;
            #1;
            check($sformatf("resweep k=%0d ready_m", k), 32'(ready_m), 32'(k >= 32));
            check($sformatf("resweep k=%0d ready_a", k), 32'(ready_a), 32'(k >= 24));
            check($sformatf("resweep k=%0d rd0_m", k), rd_m[31:0], (k >= 32) ? 32'd4 : 32'd0);
            check($sformatf("resweep k=%0d rd0_a", k), rd_a[31:0], 32'd0);
            tick();
        end

        // Directed table.
        for (int i = 0; i < 13; i++) begin
            we        = vecs[i].we;
            wa        = {vecs[i].wa1, vecs[i].wa0};
            wd        = {vecs[i].wd1, vecs[i].wd0};
            ra        = {vecs[i].ra1, vecs[i].ra0};
            probe_sel = vecs[i].ps;
            #1;
            check($sformatf("vec%0d rd0_m", i),   rd_m[31:0],  vecs[i].m0);
            check($sformatf("vec%0d rd1_m", i),   rd_m[63:32], vecs[i].m1);
            check($sformatf("vec%0d probe_m", i), probe_m,     vecs[i].mp);
            check($sformatf("vec%0d rd0_a", i),   rd_a[31:0],  vecs[i].a0);
            check($sformatf("vec%0d rd1_a", i),   rd_a[63:32], vecs[i].a1);
            check($sformatf("vec%0d probe_a", i), probe_a,     vecs[i].ap);
            tick();
        end

        // Randomised traffic against the reference model, biased toward conflicts and bypass hits.
        for (int n = 0; n < 400; n++) begin
            logic [4:0] a0, a1;
            a0 = 5'($urandom_range(0, 31));
            a1 = ($urandom_range(0, 3) == 0) ? a0 : 5'($urandom_range(0, 31));
            we = 2'($urandom_range(0, 3));
            wa = {a1, a0};
            wd = {$urandom(), $urandom()};
            ra[4:0]   = ($urandom_range(0, 2) == 0) ? a0 : 5'($urandom_range(0, 31));
            ra[9:5]   = ($urandom_range(0, 2) == 0) ? a1 : 5'($urandom_range(0, 31));
            probe_sel = 5'($urandom_range(0, 31));
            #1;
            compare_model($sformatf("rand%0d", n));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
